dmem_unit: RTL and testbench

Data-memory stage consumed by the pipeline's MEM stage: takes the effective address, store data, write strobe and access size from the pipeline and returns the full aligned 32-bit word for the pipeline's own load alignment and extension logic. It performs big-endian byte-lane merging for sub-word stores and flags misaligned stores. After reset it zero-sweeps the array. It provides a valid/ready loader port so the testbench or boot logic can preload data while the pipeline is held in its start state.

---
 rtl/dmem_if.sv | 32 +++
 rtl/dmem_unit.sv | 156 +++++++++++++++
 tb/tb_dmem_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: pipeline MEM-stage bus and preload port of the data memory.
//   master : pipeline / boot side. Drives addr, wrData, memWr, dataSize,
//            ldValid, ldAddr and ldData. Observes rdData, ldReady, busy,
//            errFlag, errAddr and storeCount.
//   slave  : the data memory, with every direction reversed.
interface dmem_if #(
    parameter int AW = 10
);
    logic [31:0]   addr;
    logic [31:0]   wrData;
    logic          memWr;
    logic [1:0]    dataSize;
    logic [31:0]   rdData;
    logic          ldValid;
    logic [AW-1:0] ldAddr;
    logic [31:0]   ldData;
    logic          ldReady;
    logic          busy;
    logic          errFlag;
    logic [31:0]   errAddr;
    logic [15:0]   storeCount;

    modport master (
        output addr, wrData, memWr, dataSize, ldValid, ldAddr, ldData,
        input  rdData, ldReady, busy, errFlag, errAddr, storeCount
    );

    modport slave (
        input  addr, wrData, memWr, dataSize, ldValid, ldAddr, ldData,
        output rdData, ldReady, busy, errFlag, errAddr, storeCount
    );
endinterface

// File: rtl/dmem_unit.sv
// dmem_unit: word-organised data memory for the pipeline MEM stage.
// It returns the whole aligned word; the pipeline does its own load
// alignment and extension. Sub-word stores are merged into big-endian
// byte lanes (addr[1:0]=00 is bits 31:24). Misaligned stores are dropped
// and flagged. After reset the array is swept to zero, and then a
// valid/ready loader may preload words whenever the pipeline is not storing.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; restarts the clear sweep
//   bus   : dmem_if.slave, which carries the pipeline bus, the loader
//           handshake and the status outputs (busy, errFlag, errAddr,
//           storeCount)
//
//   state | meaning
//   CLEAR | zero-sweep in progress; reads return 0, stores and loads ignored
//   RUN   | normal operation until the next reset
module dmem_unit #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic          misaligned;
    logic          run;
    logic          store_ok;
    logic          store_bad;
    logic          load_go;

    logic          we;
    logic [AW-1:0] widx;
    logic [31:0]   wdata;

    logic          err_flag_q;
    logic [31:0]   err_addr_q;
    logic [15:0]   store_cnt_q;

    assign run      = (state_q == RUN);
    assign word_idx = bus.addr[AW+1:2];
    assign old_word = mem[word_idx];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_idx == AW'(DEPTH - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // ---------------- store lane merge ----------------
    always_comb begin
        merged     = bus.wrData;
        misaligned = 1'b0;
        case (bus.dataSize)
            2'b00: begin
                case (bus.addr[1:0])
                    2'b00:   merged = {bus.wrData[7:0], old_word[23:0]};
                    2'b01:   merged = {old_word[31:24], bus.wrData[7:0], old_word[15:0]};
                    2'b10:   merged = {old_word[31:16], bus.wrData[7:0], old_word[7:0]};
                    default: merged = {old_word[31:8], bus.wrData[7:0]};
                endcase
            end
            2'b01: begin
                misaligned = bus.addr[0];
                if (bus.addr[1]) merged = {old_word[31:16], bus.wrData[15:0]};
                else             merged = {bus.wrData[15:0], old_word[15:0]};
            end
            default: begin
                misaligned = (bus.addr[1:0] != 2'b00);
                merged     = bus.wrData;
            end
        endcase
    end

    assign store_ok    = run & bus.memWr & ~misaligned;
    assign store_bad   = run & bus.memWr & misaligned;
    assign bus.ldReady = run & ~bus.memWr;
    assign load_go     = bus.ldValid & bus.ldReady;

    // ---------------- single write port ----------------
    // Sweep, pipeline store and loader never compete: the sweep owns CLEAR,
    // and in RUN the loader is only ready when no pipeline store is present.
    always_comb begin
        we    = 1'b0;
        widx  = word_idx;
        wdata = merged;
        if (!run) begin
            we    = 1'b1;
            widx  = clr_idx;
            wdata = '0;
        end else if (store_ok) begin
            we    = 1'b1;
        end else if (load_go) begin
            we    = 1'b1;
            widx  = bus.ldAddr;
            wdata = bus.ldData;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            if (store_bad) begin
                err_flag_q <= 1'b1;
                if (!err_flag_q) err_addr_q <= bus.addr;
            end
            if (store_ok) begin
                store_cnt_q <= store_cnt_q + 16'd1;
            end
        end
    end

    assign bus.rdData     = run ? old_word : 32'h0;
    assign bus.busy       = ~run;
    assign bus.errFlag    = err_flag_q;
    assign bus.errAddr    = err_addr_q;
    assign bus.storeCount = store_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed bench for dmem_unit with hand-computed expectations.
module tb_dmem_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    dmem_if #(.AW(10)) bus ();

    dmem_unit #(.DEPTH(1024), .AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.addr     = 32'h0;
        bus.wrData   = 32'h0;
        bus.memWr    = 1'b0;
        bus.dataSize = 2'b10;
        bus.ldValid  = 1'b0;
        bus.ldAddr   = '0;
        bus.ldData   = 32'h0;
    endtask

    // Counts edges until busy falls; bounded so a stuck sweep still ends.
    task automatic sweep_wait(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 2000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdData, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.addr     = a;
        bus.wrData   = d;
        bus.dataSize = sz;
        bus.memWr    = 1'b1;
        tick();
        bus.memWr    = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        chk("rst_busy", {31'h0, bus.busy}, 32'h1);
        chk("rst_ldready", {31'h0, bus.ldReady}, 32'h0);
        chk("rst_errflag", {31'h0, bus.errFlag}, 32'h0);
        chk("rst_erraddr", bus.errAddr, 32'h0);
        chk("rst_count", {16'h0, bus.storeCount}, 32'h0);
        chk("rst_rddata", bus.rdData, 32'h0);
        reset = 1'b0;

        sweep_wait(n);
        chk("sweep_len", n, 32'd1024);
        read_chk("clr_rd0", 32'h0, 32'h0);
        read_chk("clr_rdffc", 32'hFFC, 32'h0);

        // Loader accepted when no pipeline store is present.
        bus.ldValid = 1'b1;
        bus.ldAddr  = 10'd5;
        bus.ldData  = 32'h11223344;
        #1;
        chk("ld_ready", {31'h0, bus.ldReady}, 32'h1);
        tick();
        bus.ldValid = 1'b0;
        read_chk("ld_rd14", 32'h14, 32'h11223344);

        // Loader blocked by a simultaneous pipeline store.
        bus.ldValid  = 1'b1;
        bus.ldAddr   = 10'd6;
        bus.ldData   = 32'hDEADBEEF;
        bus.memWr    = 1'b1;
        bus.addr     = 32'h20;
        bus.wrData   = 32'hCAFEF00D;
        bus.dataSize = 2'b10;
        #1;
        chk("ld_blocked", {31'h0, bus.ldReady}, 32'h0);
        tick();
        idle();
        read_chk("ld_nowrite", 32'h18, 32'h0);
        read_chk("st_word", 32'h20, 32'hCAFEF00D);
        chk("count_1", {16'h0, bus.storeCount}, 32'd1);

        // Byte store, with read-during-write showing the old word.
        bus.addr     = 32'h15;
        bus.wrData   = 32'hFFFFFFAB;
        bus.dataSize = 2'b00;
        bus.memWr    = 1'b1;
        #1;
        chk("rdw_old", bus.rdData, 32'h11223344);
        tick();
        bus.memWr = 1'b0;
        read_chk("st_byte", 32'h14, 32'h11AB3344);

        store(32'h16, 32'h1234BEEF, 2'b01);
        read_chk("st_half", 32'h14, 32'h11ABBEEF);
        chk("count_3", {16'h0, bus.storeCount}, 32'd3);

        // Misaligned stores.
        store(32'h102, 32'hFFFFFFFF, 2'b10);
        read_chk("mis_nowrite", 32'h100, 32'h0);
        chk("mis_flag", {31'h0, bus.errFlag}, 32'h1);
        chk("mis_addr", bus.errAddr, 32'h102);
        store(32'h105, 32'h00007777, 2'b01);
        read_chk("mis2_nowrite", 32'h104, 32'h0);
        chk("mis2_addr", bus.errAddr, 32'h102);
        chk("mis_count", {16'h0, bus.storeCount}, 32'd3);

        // Address wrap aliases word 5.
        store(32'h1014, 32'h55667788, 2'b10);
        read_chk("wrap_rd", 32'h14, 32'h55667788);
        chk("count_4", {16'h0, bus.storeCount}, 32'd4);

        // Reset at sweep index 500.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        chk("mid_busy", {31'h0, bus.busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h1);
        chk("mid_rst_flag", {31'h0, bus.errFlag}, 32'h0);
        chk("mid_rst_count", {16'h0, bus.storeCount}, 32'h0);
        tick();
        bus.addr     = 32'h14;
        bus.wrData   = 32'h00000099;
        bus.dataSize = 2'b10;
        bus.memWr    = 1'b1;
        reset = 1'b0;
        sweep_wait(n);
        chk("resweep_len", n, 32'd1024);
        chk("clear_nocount", {16'h0, bus.storeCount}, 32'h0);
        bus.memWr = 1'b0;
        read_chk("resweep_rd14", 32'h14, 32'h0);

        // 65537 aligned stores wrap the counter to 1.
        bus.addr     = 32'h0;
        bus.dataSize = 2'b10;
        bus.memWr    = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bus.wrData = i;
            tick();
        end
        bus.memWr = 1'b0;
        chk("count_wrap", {16'h0, bus.storeCount}, 32'd1);
        read_chk("last_store", 32'h0, 32'h00010000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
